// File: rtl/baseline_threshold_detector_if.sv
// Stream interface between the baseline/feature producers and the threshold
// detector. The master drives enable, baseline and feature strobes. The slave
// (the detector) returns the compare result, the alarm state and the event count.
interface baseline_threshold_detector_if #(
    parameter int FEAT_W = 25,
    parameter int BASE_W = 34,
    parameter int CNT_W  = 16
);
    logic              en;
    logic [BASE_W-1:0] base_in;
    logic              base_valid;
    logic [FEAT_W-1:0] feat_in;
    logic              feat_valid;
    logic              exceed;
    logic              dout_valid;
    logic              alarm;
    logic              alarm_onset;
    logic              base_ready;
    logic [CNT_W-1:0]  event_count;

    modport master (
        output en, base_in, base_valid, feat_in, feat_valid,
        input  exceed, dout_valid, alarm, alarm_onset, base_ready, event_count
    );

    modport slave (
        input  en, base_in, base_valid, feat_in, feat_valid,
        output exceed, dout_valid, alarm, alarm_onset, base_ready, event_count
    );
endinterface

// File: rtl/baseline_threshold_detector.sv
// Flags feature samples that exceed MULT x baseline and debounces the flag
// into an alarm level. The alarm rises after CONSEC consecutive exceeding
// samples and falls after CLEAR consecutive quiet samples. The baseline is
// frozen while the alarm is active, so seizure activity cannot raise it.
module baseline_threshold_detector #(
    parameter int          FEAT_W = 25,
    parameter int          BASE_W = 34,
    parameter int unsigned MULT   = 3,
    parameter int unsigned CONSEC = 4,
    parameter int unsigned CLEAR  = 8,
    parameter int          CNT_W  = 16
) (
    input logic clk,
    input logic rst,
    baseline_threshold_detector_if.slave bus
);
    localparam int TW = BASE_W + 4;  // headroom for MULT <= 15
    localparam int RW = 8;           // run counters hold 1..255

    typedef enum logic [1:0] {
        WAIT_BASE,
        MONITOR,
        CANDIDATE,
        ALARM
    } state_t;

    state_t            state, state_nxt;
    logic [BASE_W-1:0] base_reg, base_nxt;
    logic [RW-1:0]     run_cnt, run_nxt;
    logic [RW-1:0]     clr_cnt, clr_nxt;
    logic              exceed_nxt, dout_valid_nxt, alarm_nxt, onset_nxt, ready_nxt;
    logic [CNT_W-1:0]  event_nxt;

    logic signed [TW-1:0] base_ext, thr, feat_ext;
    logic                 exceed_now;

    // Signed threshold compare against the currently latched baseline.
    always_comb begin
        base_ext   = signed'({{4{base_reg[BASE_W-1]}}, base_reg});
        thr        = base_ext * $signed(TW'(MULT));
        feat_ext   = signed'({{(TW-FEAT_W){bus.feat_in[FEAT_W-1]}}, bus.feat_in});
        exceed_now = feat_ext > thr;
    end

    // Next-state logic: baseline latch, sample processing and debounce FSM.
    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt      = state;
        base_nxt       = base_reg;
        run_nxt        = run_cnt;
        clr_nxt        = clr_cnt;
        exceed_nxt     = bus.exceed;
        dout_valid_nxt = 1'b0;
        onset_nxt      = 1'b0;
        alarm_nxt      = bus.alarm;
        ready_nxt      = bus.base_ready;
        event_nxt      = bus.event_count;

        if (!bus.en) begin
            // A baseline arriving during an alarm is dropped on purpose.
            if (bus.base_valid && state != ALARM) begin
                base_nxt  = bus.base_in;
                ready_nxt = 1'b1;
                if (state == WAIT_BASE) begin
                    state_nxt = MONITOR;
                end
            end

            // Samples before the first baseline are discarded silently.
            if (bus.feat_valid && state != WAIT_BASE) begin
                exceed_nxt     = exceed_now;
                dout_valid_nxt = 1'b1;
                case (state)
                    MONITOR, CANDIDATE: begin
                        if (exceed_now) begin
                            run_nxt = (state == MONITOR) ? RW'(1) : run_cnt + RW'(1);
                            if (run_nxt == RW'(CONSEC)) begin
                                state_nxt = ALARM;
                                alarm_nxt = 1'b1;
                                onset_nxt = 1'b1;
                                clr_nxt   = '0;
                                if (bus.event_count != '1) begin
                                    event_nxt = bus.event_count + CNT_W'(1);
                                end
                            end else begin
                                state_nxt = CANDIDATE;
                            end
                        end else begin
                            run_nxt   = '0;
                            state_nxt = MONITOR;
                        end
                    end
                    ALARM: begin
                        if (exceed_now) begin
                            clr_nxt = '0;
                        end else begin
                            clr_nxt = clr_cnt + RW'(1);
                            if (clr_nxt == RW'(CLEAR)) begin
                                state_nxt = MONITOR;
                                alarm_nxt = 1'b0;
                                run_nxt   = '0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // State register with synchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= WAIT_BASE;
            base_reg        <= '0;
            run_cnt         <= '0;
            clr_cnt         <= '0;
            bus.exceed      <= 1'b0;
            bus.dout_valid  <= 1'b0;
            bus.alarm       <= 1'b0;
            bus.alarm_onset <= 1'b0;
            bus.base_ready  <= 1'b0;
            bus.event_count <= '0;
        end else begin
            state           <= state_nxt;
            base_reg        <= base_nxt;
            run_cnt         <= run_nxt;
            clr_cnt         <= clr_nxt;
            bus.exceed      <= exceed_nxt;
            bus.dout_valid  <= dout_valid_nxt;
            bus.alarm       <= alarm_nxt;
            bus.alarm_onset <= onset_nxt;
            bus.base_ready  <= ready_nxt;
            bus.event_count <= event_nxt;
        end
    end
endmodule

// File: tb/tb_baseline_threshold_detector.sv
// Self-checking bench for baseline_threshold_detector: directed scenarios
// followed by randomized traffic, all compared every cycle against a
// history-based reference model.
module tb_baseline_threshold_detector;
    localparam int          FEAT_W = 25;
    localparam int          BASE_W = 34;
    localparam int unsigned MULT   = 3;
    localparam int unsigned CONSEC = 4;
    localparam int unsigned CLEAR  = 8;
    localparam int          CNT_W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    baseline_threshold_detector_if #(.FEAT_W(FEAT_W), .BASE_W(BASE_W), .CNT_W(CNT_W)) bus ();

    baseline_threshold_detector #(
        .FEAT_W(FEAT_W), .BASE_W(BASE_W), .MULT(MULT),
        .CONSEC(CONSEC), .CLEAR(CLEAR), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a baseline value, a ready flag, an alarm flag and the
    // list of compare results seen since the alarm last changed.
    longint m_base;
    bit     m_ready, m_alarm, m_exceed, m_dv, m_onset;
    longint m_events;
    bit     hist[$];

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic bit last_all(input int n, input bit v);
        if (hist.size() < n) return 1'b0;
        for (int i = hist.size() - n; i < hist.size(); i++)
            if (hist[i] != v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_base = 0; m_ready = 0; m_alarm = 0; m_exceed = 0;
        m_dv = 0; m_onset = 0; m_events = 0;
        hist.delete();
    endtask

    task automatic model_step(input bit r, input bit e, input bit bv, input longint bi,
                              input bit fv, input longint fi);
        bit was_alarm, was_ready;
        if (!r) begin
            model_reset();
            return;
        end
        m_dv = 0;
        m_onset = 0;
        if (e) return;
        was_alarm = m_alarm;
        was_ready = m_ready;
        if (fv && was_ready) begin
            m_exceed = fi > m_base * longint'(MULT);
            m_dv = 1;
            hist.push_back(m_exceed);
            if (hist.size() > 300) void'(hist.pop_front());
            if (!m_alarm && last_all(CONSEC, 1'b1)) begin
                m_alarm = 1; m_onset = 1;
                if (m_events < (2**CNT_W) - 1) m_events++;
                hist.delete();
            end else if (m_alarm && last_all(CLEAR, 1'b0)) begin
                m_alarm = 0;
                hist.delete();
            end
        end
        if (bv && !was_alarm) begin
            m_base = bi;
            m_ready = 1;
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare after it.
    task automatic step(input bit r, input bit e, input bit bv, input longint bi,
                        input bit fv, input longint fi);
        logic [63:0] bw, fw;
        bw = bi;
        fw = fi;
        @(negedge clk);
        rst            = r;
        bus.en         = e;
        bus.base_valid = bv;
        bus.base_in    = bw[BASE_W-1:0];
        bus.feat_valid = fv;
        bus.feat_in    = fw[FEAT_W-1:0];
        @(posedge clk);
        model_step(r, e, bv, bi, fv, fi);
        #1;
        check("exceed",      longint'(bus.exceed),      longint'(m_exceed));
        check("dout_valid",  longint'(bus.dout_valid),  longint'(m_dv));
        check("alarm",       longint'(bus.alarm),       longint'(m_alarm));
        check("alarm_onset", longint'(bus.alarm_onset), longint'(m_onset));
        check("base_ready",  longint'(bus.base_ready),  longint'(m_ready));
        check("event_count", longint'(bus.event_count), m_events);
    endtask

    task automatic idle();           step(1, 0, 0, 0, 0, 0);  endtask
    task automatic base(input longint b);  step(1, 0, 1, b, 0, 0);  endtask
    task automatic feat(input longint f);  step(1, 0, 0, 0, 1, f);  endtask
    task automatic do_reset();       step(0, 0, 0, 0, 0, 0);  endtask

    initial begin
        int feats_a[8];
        bus.en = 0; bus.base_valid = 0; bus.base_in = '0;
        bus.feat_valid = 0; bus.feat_in = '0;
        model_reset();

        // Reset state, basic strict compare.
        do_reset();
        check("rst_event_count", longint'(bus.event_count), 0);
        base(100);
        feat(301);
        check("feat301_exceed", longint'(bus.exceed), 1);
        feat(300);
        check("feat300_exceed", longint'(bus.exceed), 0);

        // Samples before any baseline are discarded.
        do_reset();
        feat(500); feat(-5); feat(999);
        check("wait_base_ready", longint'(bus.base_ready), 0);
        base(50);
        feat(151);
        check("base50_exceed", longint'(bus.exceed), 1);

        // Debounce into alarm on the eighth sample.
        do_reset();
        base(100);
        feats_a = '{400, 400, 400, 0, 400, 400, 400, 400};
        for (int i = 0; i < 8; i++) feat(feats_a[i]);
        check("onset_pulse", longint'(bus.alarm_onset), 1);
        check("onset_events", longint'(bus.event_count), 1);

        // Hold alarm across a broken quiet run; ignore baseline during alarm.
        for (int i = 0; i < 7; i++) feat(0);
        base(1000);
        feat(400);
        for (int i = 0; i < 7; i++) feat(0);
        check("alarm_held", longint'(bus.alarm), 1);
        feat(0);
        check("alarm_dropped", longint'(bus.alarm), 0);
        feat(301);
        check("ignored_base", longint'(bus.exceed), 1);

        // Negative baseline and simultaneous base/feature strobes.
        do_reset();
        base(-10);
        feat(0);
        check("neg_base_hi", longint'(bus.exceed), 1);
        feat(-31);
        check("neg_base_lo", longint'(bus.exceed), 0);
        step(1, 0, 1, 200, 1, 301);
        check("simul_old_base", longint'(bus.exceed), 1);
        feat(301);
        check("simul_new_base", longint'(bus.exceed), 0);

        // Freeze mid-candidate, then reset mid-alarm.
        do_reset();
        base(100);
        feat(400); feat(400);
        for (int i = 0; i < 5; i++) step(1, 1, 1, 7, 1, 0);
        feat(400);
        check("frozen_run_alarm", longint'(bus.alarm), 0);
        feat(400);
        check("frozen_run_onset", longint'(bus.alarm_onset), 1);
        step(0, 0, 1, 5, 1, 400);
        check("rst_alarm", longint'(bus.alarm), 0);
        check("rst_events", longint'(bus.event_count), 0);

        // Randomized traffic around the current threshold.
        base(20);
        for (int n = 0; n < 1500; n++) begin
            bit     r, e, bv, fv;
            longint bi, fi;
            r  = ($urandom_range(0, 199) != 0);
            e  = ($urandom_range(0, 9) == 0);
            bv = ($urandom_range(0, 19) == 0);
            fv = ($urandom_range(0, 9) < 7);
            bi = longint'($urandom_range(0, 300)) - 100;
            if ($urandom_range(0, 1) == 1)
                fi = m_base * longint'(MULT) + longint'($urandom_range(0, 3)) - 1;
            else
                fi = longint'($urandom_range(0, 2000)) - 1000;
            step(r, e, bv, bi, fv, fi);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/baseline_threshold_detector.md
Name: baseline_threshold_detector

Overview:
- Consumes the baseline stream (already shifted by 8) plus the live per-second feature stream, and flags samples whose feature exceeds MULT × baseline.
- A debounce FSM raises an alarm to the controller after CONSEC consecutive exceeding samples. It clears the alarm after CLEAR consecutive non-exceeding samples.
- Sits downstream of the baseline calculator, at the receiving end of its dout/data_valid interface.

Parameters:
- FEAT_W, 25, feature sample width (signed).
- BASE_W, 34, baseline input width (signed).
- MULT, 3, unsigned integer threshold multiplier, 1..15.
- CONSEC, 4, consecutive exceeding samples required to raise the alarm, 1..255.
- CLEAR, 8, consecutive non-exceeding samples required to drop the alarm, 1..255.
- CNT_W, 16, event counter width.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous reset, active-low.
- en, input, 1, active-low enable; when high all state freezes and inputs are ignored.
- base_in, input, BASE_W, signed baseline value.
- base_valid, input, 1, one-cycle strobe; base_in is valid.
- feat_in, input, FEAT_W, signed feature sample.
- feat_valid, input, 1, one-cycle strobe; feat_in is valid.
- exceed, output, 1, registered compare result for the last processed sample.
- dout_valid, output, 1, one-cycle pulse; exceed is updated.
- alarm, output, 1, level; seizure-candidate state is active.
- alarm_onset, output, 1, one-cycle pulse on the 0→1 transition of alarm.
- base_ready, output, 1, a baseline has been latched since reset.
- event_count, output, CNT_W, number of alarm onsets; saturates at all-ones.

Behaviour:
- Reset (rst==0 at posedge):
  - All outputs are 0; event_count is 0.
  - base_reg is 0; both run counters are 0; state is WAIT_BASE.
  - Reset overrides en and all strobes, including mid-alarm.
- Freeze: when en==1, registers hold their values. dout_valid and alarm_onset are forced to 0 that cycle. Strobes arriving in that cycle are lost.
- Baseline latch:
  - On base_valid, base_reg <= base_in and base_ready <= 1.
  - Exception: in ALARM, base_valid is dropped so seizure activity does not contaminate the baseline.
- Threshold arithmetic:
  - thr = base_reg × MULT, computed at BASE_W+4 bits signed.
  - feat_in is sign-extended to BASE_W+4.
  - exceed_now = (feat_ext > thr), strict greater-than.
  - A negative baseline is legal and compared signed.
- Sample processing (feat_valid==1 and en==0):
  - In WAIT_BASE the sample is discarded with no dout_valid.
  - Otherwise, at the next edge: exceed <= exceed_now and dout_valid <= 1. Latency is 1 cycle.
- Simultaneous base_valid and feat_valid: the compare uses the old base_reg. The new value applies from the next sample.
- FSM, advanced only on processed samples:
  - WAIT_BASE → MONITOR on the first accepted base_valid.
  - MONITOR:
    - exceed_now: run=1; if CONSEC==1 go to ALARM, else go to CANDIDATE.
    - Otherwise: run=0.
  - CANDIDATE:
    - exceed_now: run++; when run reaches CONSEC, go to ALARM.
    - Not exceed_now: run=0 and return to MONITOR.
  - Entering ALARM:
    - alarm <= 1 in the same edge as that sample's dout_valid.
    - alarm_onset pulses for 1 cycle.
    - event_count++ (saturating); clr=0.
  - ALARM:
    - Not exceed_now: clr++; when clr reaches CLEAR, go to MONITOR, with alarm <= 0 on that edge.
    - exceed_now: clr=0.
- Counters are sized to hold 255 and never wrap.
- Strobes that arrive with feat_valid low only affect the baseline latch.

Test Plan:
- Reset, then base_in=100 with base_valid, then feat 301 → exceed=1, dout_valid at +1 cycle; feat 300 → exceed=0 (strict compare).
- Feats before any base_valid → no dout_valid, alarm=0, base_ready=0; after base_valid=50, feat 151 → exceed=1.
- base=100, feats 400,400,400,0,400,400,400,400 → no alarm through sample 7; alarm=1 and alarm_onset pulse with sample 8; event_count=1.
- In ALARM, 7 low feats, 1 high, 8 low → alarm stays 1 until the 8th consecutive low, then drops. A base_valid=1000 issued during ALARM is ignored: a following feat 301 still gives exceed=1.
- base=-10 → feat 0 gives exceed=1 (thr=-30); feat -31 gives exceed=0. Simultaneous base_valid=200 with feat 301 → exceed=1; the next feat 301 → exceed=0.
- en=1 for 5 cycles mid-CANDIDATE with feat_valid strobes → no outputs and run preserved. Then rst=0 mid-ALARM → all outputs 0 and event_count=0 on the next edge.
